// File: rtl/seq_checker.sv
// seq_checker
//   Checks a free-running 32-bit Fibonacci stream (0,1,1,2,3,5,...) one
//   sample per clock. Each sample is compared with the sum (mod 2^32) of the
//   two previously observed samples. The block counts samples and
//   mismatches, captures the first failure and flags arithmetic wrap.
//
// Parameters
//   CNT_W       width of the sample/error counters (both saturate)
//   CHECK_SEED  1: first two samples must be 0 and 1; 0: seeds unchecked
//
// Ports
//   clk              clock, all state changes on posedge
//   reset            asynchronous, active-high reset
//   clear_i          synchronous restart; the sample that cycle is ignored
//   seq_i            sequence value, sampled every clock
//   locked_o         high while checking (both seeds loaded)
//   mismatch_o       one-cycle pulse: the previous sample mismatched
//   err_o            sticky: any mismatch since reset/clear
//   wrap_o           sticky: an expected value's addition carried out
//   sample_cnt_o     samples taken since reset/clear (saturating)
//   err_cnt_o        mismatches since reset/clear (saturating)
//   first_err_idx_o  sample index of the first mismatch
//   first_err_exp_o  expected value at the first mismatch
//   first_err_act_o  observed value at the first mismatch
module seq_checker #(
    parameter int CNT_W      = 32,
    parameter bit CHECK_SEED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [31:0]      seq_i,
    output logic             locked_o,
    output logic             mismatch_o,
    output logic             err_o,
    output logic             wrap_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] first_err_idx_o,
    output logic [31:0]      first_err_exp_o,
    output logic [31:0]      first_err_act_o
);

    typedef enum logic [1:0] {
        SEED0 = 2'd0,
        SEED1 = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      h1_q, h1_d;
    logic [31:0]      h2_q, h2_d;
    logic             mismatch_q, mismatch_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [31:0]      fexp_q, fexp_d;
    logic [31:0]      fact_q, fact_d;

    logic [32:0]      sum_w;
    logic [31:0]      exp_w;
    logic             mis_w;

    // Counters hold at all-ones instead of rolling over.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = SEED0;
        end else begin
            case (state_q)
                SEED0:   state_d = SEED1;
                SEED1:   state_d = CHECK;
                CHECK:   state_d = CHECK;
                default: state_d = SEED0;
            endcase
        end
    end

    // Expected value: fixed seeds, then the 33-bit sum of the history; the
    // compare only looks at the low 32 bits, the carry just feeds wrap.
    always_comb begin
        sum_w = {1'b0, h1_q} + {1'b0, h2_q};
        case (state_q)
            SEED0:   exp_w = 32'd0;
            SEED1:   exp_w = 32'd1;
            default: exp_w = sum_w[31:0];
        endcase
        if (state_q == CHECK) begin
            mis_w = (seq_i != exp_w);
        end else begin
            mis_w = CHECK_SEED && (seq_i != exp_w);
        end
    end

    always_comb begin
        h1_d         = h1_q;
        h2_d         = h2_q;
        mismatch_d   = 1'b0;
        err_d        = err_q;
        wrap_d       = wrap_q;
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        fidx_d       = fidx_q;
        fexp_d       = fexp_q;
        fact_d       = fact_q;
        if (clear_i) begin
            h1_d         = 32'd0;
            h2_d         = 32'd0;
            err_d        = 1'b0;
            wrap_d       = 1'b0;
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            fidx_d       = '0;
            fexp_d       = 32'd0;
            fact_d       = 32'd0;
        end else begin
            // History always follows the observed value so a single bad
            // sample only disturbs the next two checks.
            case (state_q)
                SEED0: h2_d = seq_i;
                SEED1: h1_d = seq_i;
                default: begin
                    h2_d = h1_q;
                    h1_d = seq_i;
                    if (sum_w[32]) begin
                        wrap_d = 1'b1;
                    end
                end
            endcase
            sample_cnt_d = sat_inc(sample_cnt_q);
            if (mis_w) begin
                mismatch_d = 1'b1;
                err_d      = 1'b1;
                err_cnt_d  = sat_inc(err_cnt_q);
                if (!err_q) begin
                    fidx_d = sample_cnt_q;
                    fexp_d = exp_w;
                    fact_d = seq_i;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h1_q         <= 32'd0;
            h2_q         <= 32'd0;
            mismatch_q   <= 1'b0;
            err_q        <= 1'b0;
            wrap_q       <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            fidx_q       <= '0;
            fexp_q       <= 32'd0;
            fact_q       <= 32'd0;
        end else begin
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            mismatch_q   <= mismatch_d;
            err_q        <= err_d;
            wrap_q       <= wrap_d;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            fidx_q       <= fidx_d;
            fexp_q       <= fexp_d;
            fact_q       <= fact_d;
        end
    end

    assign locked_o        = (state_q == CHECK);
    assign mismatch_o      = mismatch_q;
    assign err_o           = err_q;
    assign wrap_o          = wrap_q;
    assign sample_cnt_o    = sample_cnt_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_idx_o = fidx_q;
    assign first_err_exp_o = fexp_q;
    assign first_err_act_o = fact_q;

endmodule
